// File: rtl/histogram_equalizer.sv
// histogram_equalizer: remaps one IDCT table through the histogram RAM's CDF into equalized pixels
module histogram_equalizer #(
  parameter int IMAGE_WIDTH = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_WIDTH = 8,
  parameter int DC_OFFSET = 128,
  parameter int TABLE_SIZE = 64,
  parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH,
  parameter int HISTOGRAM_RAM_DATA_WIDTH = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [TABLE_SIZE*PIXEL_WIDTH-1:0]      image_table,
  input  logic                                   start_equalization,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    CDF_min,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_data_input,
  output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_address,
  output logic                                   histogram_RAM_CE,
  output logic                                   histogram_RAM_WE,
  output logic [TABLE_SIZE*PIXEL_WIDTH-1:0]      equalized_table,
  output logic                                   busy,
  output logic                                   equalization_done
);
  localparam int DW = HISTOGRAM_RAM_DATA_WIDTH;
  localparam int PW = PIXEL_WIDTH;
  localparam int NW = DW + PW;
  localparam int IW = $clog2(TABLE_SIZE);
  localparam int CW = $clog2(NW);
  localparam logic [DW-1:0] N = DW'(IMAGE_WIDTH * IMAGE_HEIGHT);
  localparam logic [PW-1:0] OFF = PW'(DC_OFFSET);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, DIVIDE, STORE, DONE} state_t;
  state_t state, next;
  logic [TABLE_SIZE-1:0][PW-1:0] tbl, eq;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem, den, diff;
  logic [NW-1:0] quo;
  logic [DW:0] trial;
  logic den_zero, fits;
  assign equalized_table = eq;
  assign histogram_RAM_WE = 1'b0;
  assign diff = histogram_RAM_data_input - CDF_min;
  assign trial = {rem, quo[NW-1]};
  assign fits = trial >= {1'b0, den};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE    ? (start_equalization ? READ : IDLE) :
           state == READ    ? CAPTURE :
           state == CAPTURE ? DIVIDE :
           state == DIVIDE  ? (cnt == CW'(NW - 1) ? STORE : DIVIDE) :
           state == STORE   ? (idx == IW'(TABLE_SIZE - 1) ? DONE : READ) : IDLE;
  always_comb begin
    busy = state inside {READ, CAPTURE, DIVIDE, STORE};
    equalization_done = state == DONE;
    histogram_RAM_CE = state inside {READ, CAPTURE};
    histogram_RAM_address = state inside {READ, CAPTURE} ? HISTOGRAM_RAM_ADDRESS_WIDTH'(tbl[idx] + OFF) : '0;
  end
  // quo starts as the dividend and shifts quotient bits in from the right as the remainder consumes it
  always_ff @(posedge clk)
    if (rst) begin
      tbl <= '0;
      eq <= '0;
      idx <= '0;
      cnt <= '0;
      rem <= '0;
      den <= '0;
      quo <= '0;
      den_zero <= 1'b0;
    end else begin
      if (state == IDLE && start_equalization) begin
        tbl <= image_table;
        idx <= '0;
      end
      if (state == CAPTURE) begin
        quo <= histogram_RAM_data_input > CDF_min ? {diff, PW'(0)} - NW'(diff) : '0;
        rem <= '0;
        cnt <= '0;
        den <= N - CDF_min;
        den_zero <= CDF_min >= N;
      end
      if (state == DIVIDE) begin
        rem <= fits ? DW'(trial - {1'b0, den}) : trial[DW-1:0];
        quo <= {quo[NW-2:0], fits};
        cnt <= cnt + 1'b1;
      end
      if (state == STORE) begin
        eq[idx] <= den_zero ? '0 : |quo[NW-1:PW] ? '1 : quo[PW-1:0];
        idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_histogram_equalizer.sv
// tb_histogram_equalizer: directed vectors plus random tables against an arithmetic CDF-remap model
module tb_histogram_equalizer;
  localparam int N = 76800;
  typedef struct {
    logic [7:0] pix;
    int ram_val;
    int cdf_min;
    int exp;
  } vec_t;
  logic clk = 0, rst = 1, start = 0;
  logic [511:0] image_table = '0;
  logic [16:0] cdf_min = '0, ram_q = '0;
  logic [7:0] addr;
  logic ce, we, busy, done, we_seen;
  logic [511:0] eq_tbl;
  int ram[256];
  int checks = 0, errors = 0;
  logic [7:0] ce_addrs[$];
  vec_t vecs[6];

  histogram_equalizer dut (
    .clk(clk), .rst(rst), .image_table(image_table), .start_equalization(start),
    .CDF_min(cdf_min), .histogram_RAM_data_input(ram_q), .histogram_RAM_address(addr),
    .histogram_RAM_CE(ce), .histogram_RAM_WE(we), .equalized_table(eq_tbl),
    .busy(busy), .equalization_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ce) ram_q <= 17'(ram[addr]);
  always @(negedge clk) begin
    if (ce) ce_addrs.push_back(addr);
    if (we) we_seen = 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int addr_of(input logic [511:0] t, input int i);
    return (int'(t[i*8 +: 8]) + 128) % 256;
  endfunction

  function automatic int model(input logic [511:0] t, input int i, input int mn);
    longint c, q;
    c = ram[addr_of(t, i)];
    if (mn >= N || c <= mn) return 0;
    q = (c - mn) * 255 / (N - mn);
    return q > 255 ? 255 : int'(q);
  endfunction

  // mode 0: plain run, 1: extra start while busy, 2: table input changed mid-run
  task automatic run(input string name, input logic [511:0] t, input int mn, input int mode);
    int n;
    logic busy_ok, seq_ok;
    n = 0;
    busy_ok = 1;
    @(negedge clk);
    image_table = t;
    cdf_min = 17'(mn);
    start = 1;
    ce_addrs.delete();
    we_seen = 0;
    @(negedge clk);
    start = 0;
    while (!done && n < 3000) begin
      if (!busy) busy_ok = 0;
      if (mode == 1) start = n == 100;
      if (mode == 2 && n == 50) image_table = ~t;
      @(negedge clk);
      n++;
    end
    start = 0;
    chk({name, " latency"}, n, 1792);
    chk({name, " busy_during_run"}, busy_ok, 1);
    chk({name, " busy_at_done"}, busy, 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s px%0d", name, i), eq_tbl[i*8 +: 8], model(t, i, mn));
    seq_ok = ce_addrs.size() == 128;
    for (int i = 0; i < 64 && seq_ok; i++)
      seq_ok = ce_addrs[2*i] == 8'(addr_of(t, i)) && ce_addrs[2*i+1] == 8'(addr_of(t, i));
    chk({name, " addr_seq"}, seq_ok, 1);
    chk({name, " we"}, we_seen, 0);
    @(negedge clk);
    chk({name, " done_width"}, done, 0);
    chk({name, " idle_after"}, busy, 0);
  endtask

  task automatic rand_fill(output logic [511:0] t);
    for (int i = 0; i < 256; i++) ram[i] = $urandom_range(0, N);
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
  endtask

  initial begin
    logic [511:0] t;
    int n;
    logic no_done;
    vecs[0] = '{8'sd127, 76800, 0, 255};
    vecs[1] = '{8'sd0, 38400, 0, 127};
    vecs[2] = '{8'h80, 300, 300, 0};
    vecs[3] = '{8'sd72, 40000, 1000, 131};
    vecs[4] = '{8'sd5, 76800, 76800, 0};
    vecs[5] = '{8'hfd, 10, 20, 0};
    foreach (ram[i]) ram[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ce", ce, 0);
    chk("reset we", we, 0);
    chk("reset addr", addr, 0);
    chk("reset table", |eq_tbl, 0);
    rst = 0;
    for (int v = 0; v < 6; v++) begin
      foreach (ram[i]) ram[i] = 0;
      t = {64{vecs[v].pix}};
      ram[addr_of(t, 0)] = vecs[v].ram_val;
      run($sformatf("vec%0d", v), t, vecs[v].cdf_min, 0);
      chk($sformatf("vec%0d table_exp", v), eq_tbl[7:0], vecs[v].exp);
      chk($sformatf("vec%0d table_last", v), eq_tbl[511:504], vecs[v].exp);
    end
    for (int r = 0; r < 3; r++) begin
      rand_fill(t);
      run($sformatf("rand%0d", r), t, $urandom_range(0, 3000), 0);
    end
    rand_fill(t);
    run("restart_ignored", t, $urandom_range(0, 2000), 1);
    rand_fill(t);
    run("table_latched", t, $urandom_range(0, 2000), 2);
    rand_fill(t);
    run("degenerate_rand", t, N, 0);
    rand_fill(t);
    @(negedge clk);
    image_table = t;
    cdf_min = 17'(100);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    no_done = 1;
    while (n < 500) begin
      if (done) no_done = 0;
      @(negedge clk);
      n++;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst busy", busy, 0);
    chk("midrst table", |eq_tbl, 0);
    for (int i = 0; i < 5; i++) begin
      if (done) no_done = 0;
      @(negedge clk);
    end
    chk("midrst no_done", no_done, 1);
    run("after_reset", t, 100, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/histogram_equalizer.md
Name: histogram_equalizer

Overview:
- Reads the CDF that the histogram/CDF generator leaves in the histogram RAM.
- Remaps one 8x8 IDCT output table into histogram-equalized pixels: out = floor((CDF[p+DC_OFFSET] - CDF_min) * (2^PIXEL_WIDTH - 1) / (N - CDF_min)), where N = IMAGE_WIDTH*IMAGE_HEIGHT.
- Sits after CDF generation and before the output pixel buffer. It is the read-only consumer of the histogram RAM.

Parameters:
- IMAGE_WIDTH, 320, image width in pixels.
- IMAGE_HEIGHT, 240, image height in pixels.
- PIXEL_WIDTH, 8, bits per pixel.
- DC_OFFSET, 128, level shift added to signed IDCT pixels to form the RAM address.
- TABLE_SIZE, 64, pixels per table (square, 8x8).
- HISTOGRAM_RAM_ADDRESS_WIDTH, PIXEL_WIDTH, RAM address width.
- HISTOGRAM_RAM_DATA_WIDTH, clog2(IMAGE_WIDTH*IMAGE_HEIGHT) (17), CDF word width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- image_table  input  TABLE_SIZE*PIXEL_WIDTH  signed IDCT pixels; pixel i = w + h*8 at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- start_equalization  input  1  single-cycle start request.
- CDF_min  input  HISTOGRAM_RAM_DATA_WIDTH  minimum CDF value, stable while busy.
- histogram_RAM_data_input  input  HISTOGRAM_RAM_DATA_WIDTH  RAM read data, valid the cycle after the address is presented with CE=1.
- histogram_RAM_address  output  HISTOGRAM_RAM_ADDRESS_WIDTH  RAM address.
- histogram_RAM_CE  output  1  RAM chip enable.
- histogram_RAM_WE  output  1  RAM write enable; constant 0.
- equalized_table  output  TABLE_SIZE*PIXEL_WIDTH  unsigned equalized pixels, same packing as image_table.
- busy  output  1  high from the cycle after start is accepted until done.
- equalization_done  output  1  one-cycle pulse when equalized_table is complete.

Behaviour:
- Reset: state IDLE; busy=0, equalization_done=0, equalized_table=0, CE=0, WE=0, address=0. All indices and the divider are cleared.
- Reset mid-operation aborts immediately. No done pulse; equalized_table is cleared.
- Start handling:
  - start_equalization is sampled only in IDLE.
  - On acceptance, image_table is latched into an internal register. Later input changes have no effect on the current operation.
  - Start while busy is ignored.
- Pixel loop, index 0..63, ascending:
  - READ: CE=1; address = (pixel + DC_OFFSET) mod 2^PIXEL_WIDTH, so -128 maps to 0 and 127 maps to 255.
  - CAPTURE: CE=1, same address. Latch the RAM data as cdf. Compute:
    - num = (cdf > CDF_min) ? (cdf - CDF_min) * 255 : 0, width NW = HISTOGRAM_RAM_DATA_WIDTH + PIXEL_WIDTH (25).
    - den = N - CDF_min.
  - DIVIDE: restoring shift-subtract division, one quotient bit per cycle, exactly NW cycles. CE=0.
  - STORE: write the quotient into slot i of equalized_table.
    - Clamp the quotient to 255 if it exceeds 255.
    - If den == 0 (CDF_min >= N), store 0.
    - Advance the index. After index 63, go to DONE; otherwise go to READ.
  - DONE: equalization_done=1 for one cycle, busy drops, return to IDLE.
- Cycle counts (fixed, data-independent; den==0 still takes NW divide cycles):
  - NW + 3 = 28 cycles per pixel.
  - Done is high in the cycle after edge E0 + 64*28 = 1792, where E0 is the edge at which start is sampled.
- equalized_table slots not yet processed hold their previous values until overwritten. The full table is valid only at done.
- A new start can be accepted in the cycle after done (IDLE).
- The RAM is never written. WE stays 0 in every state.

Test Plan:
- Full CDF: all 64 pixels = 127, RAM[255]=76800, CDF_min=0 -> address 255 with CE in READ/CAPTURE; all outputs 255; done exactly 1792 cycles after start; busy high throughout.
- Midpoint with floor: pixel 0 (address 128), RAM[128]=38400, CDF_min=0 -> output 127 (127.5 floored); pixel -128 with RAM[0]=300, CDF_min=300 -> 0.
- Nonzero minimum: RAM[200]=40000, CDF_min=1000, pixel 72 -> floor(39000*255/75800) = 131.
- Degenerate: CDF_min=76800 with any RAM data -> all outputs 0, same 1792-cycle latency. Separately, RAM value 10 with CDF_min=20 -> 0.
- Control: second start at cycle 100 is ignored and done pulses once. Change image_table mid-run -> results use the latched table.
- Reset: rst at cycle 500 -> next cycle busy=0, equalized_table=0, no done pulse. A following start completes normally with correct values.
